mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single 64-bit synchronous RAM port (dpram64 style: one address, byte-write enables, 1-cycle read latency) between two requesters.
- Port 0 is normally the AXI-to-memory bridge; port 1 is a DMA/boot-loader engine.
- Arbitration is round-robin, with an optional lock so a requester can hold the port across a multi-beat sequence.
- Read data is returned to the owner one cycle after its granted read.

Parameters:
- AW, 32, byte-address width on requester and memory sides.
- LOCK_MAX, 16, maximum consecutive granted beats under lock before a forced release; 0 = unlimited.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_req0 / i_req1  in  1  access request, held until granted
- i_we0 / i_we1  in  1  1 = write, 0 = read
- i_lock0 / i_lock1  in  1  keep ownership after this beat
- i_addr0 / i_addr1  in  AW  byte address; bits [2:0] ignored
- i_be0 / i_be1  in  8  byte enables
- i_wdata0 / i_wdata1  in  64  write data
- o_gnt0 / o_gnt1  out  1  request accepted this cycle
- o_rvalid0 / o_rvalid1  out  1  read data valid for that port
- o_rdata  out  64  read data, shared; qualified by o_rvalidN
- o_mem_we  out  8  byte write enables to RAM
- o_mem_addr  out  AW  RAM address, bits [2:0] forced to 0
- o_mem_wdata  out  64  RAM write data
- i_mem_rdata  in  64  RAM read data, valid 1 cycle after address

Behaviour:
- Reset (async assert, sync deassert by the system):
  - o_rvalid0/1 = 0.
  - Last-grant pointer = 1, so port 0 wins the first tie.
  - FSM = ARB, lock counter = 0.
- o_gnt*, o_mem_* are combinational from inputs and state, so a grant occurs in the request cycle (zero-wait).
- FSM states:
  - ARB:
    - Only one req set → grant it.
    - Both set → grant the port not equal to the last-grant pointer.
    - On any grant the pointer updates to the granted port.
    - If the granted port's lock is set → go to HOLDn, counter = 1.
  - HOLD0 / HOLD1:
    - Only the owner can be granted; the other port waits even if the owner is idle.
    - Owner beat with lock=1 → stay, counter+1.
    - Owner beat with lock=0 → return to ARB.
    - Owner deasserts req and lock together → return to ARB.
    - Counter reaches LOCK_MAX on a granted beat → forced return to ARB. The pointer stays at the owner, so the other port wins the next tie.
- Memory drive:
  - Granted write: o_mem_we = be.
  - Granted read or no grant: o_mem_we = 0.
  - o_mem_addr / o_mem_wdata = granted port's values. With no grant they keep port 0's values, and we = 0.
- Read return:
  - A granted read in cycle N sets o_rvalidN in cycle N+1 for exactly one cycle.
  - o_rdata = i_mem_rdata, passed through combinationally in cycle N+1.
  - Back-to-back reads give continuous rvalid.
  - A write grant never produces rvalid.
- Simultaneous: at most one gnt and at most one rvalid per cycle. A read return and a new grant may overlap (pipelined).
- Requesters must hold addr/we/be/wdata stable while req is set and gnt is low.
- A req dropped without gnt is legal and is simply withdrawn.
- Reset mid-lock → ARB, any pending rvalid is discarded.
- Width rule: addresses are passed through unmodified except [2:0] = 0. No wrap or range check; the RAM decodes the low bits.

Test Plan:
- Reset then req0 only, read addr 0x10 → gnt0 same cycle, o_mem_addr=0x10, o_mem_we=0. Next cycle rvalid0=1, o_rdata=RAM word @0x10; rvalid1 stays 0.
- req0 and req1 held together 4 cycles, no lock → grants alternate 0,1,0,1. Each read returns rvalid on the matching port one cycle later.
- Port1 write addr 0x2B, be=0x0F, data 0x1122334455667788 → o_mem_addr=0x28, o_mem_we=0x0F, no rvalid. A subsequent read @0x28 returns the low 4 bytes updated.
- Port1 locks for 3 beats while req0 is held:
  - gnt1 for 3 consecutive cycles, no gnt0.
  - gnt0 on the cycle after the unlocked final beat.
- LOCK_MAX=4, port0 holds lock continuously with req1 pending → 4 gnt0 beats, then gnt1 next cycle.
- rst_n asserted in HOLD1 with a read just granted → o_rvalid1=0 immediately. After release, a tie grants port 0 first.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single 64-bit synchronous RAM port: round-robin
// with optional lock, zero-wait combinational grant, 1-cycle read return.
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req0,
  input  logic          i_req1,
  input  logic          i_we0,
  input  logic          i_we1,
  input  logic          i_lock0,
  input  logic          i_lock1,
  input  logic [AW-1:0] i_addr0,
  input  logic [AW-1:0] i_addr1,
  input  logic [7:0]    i_be0,
  input  logic [7:0]    i_be1,
  input  logic [63:0]   i_wdata0,
  input  logic [63:0]   i_wdata1,
  output logic          o_gnt0,
  output logic          o_gnt1,
  output logic          o_rvalid0,
  output logic          o_rvalid1,
  output logic [63:0]   o_rdata,
  output logic [7:0]    o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [63:0]   o_mem_wdata,
  input  logic [63:0]   i_mem_rdata
);

  typedef enum logic [1:0] {ARB, HOLD0, HOLD1} state_t;

  localparam int            CW   = $clog2(LOCK_MAX + 2) + 1;
  localparam logic [CW-1:0] LMAX = CW'(LOCK_MAX);

  state_t        r_state, w_state_nxt;
  logic          r_last, w_last_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic          w_cap_hit;
  logic          w_gnt0, w_gnt1;
  logic          w_glock, w_oreq, w_olock;
  logic          r_rvalid0_p1, r_rvalid1_p1;
  logic [AW-1:0] w_addr_sel;
  logic          w_unused;

  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_glock     = 1'b0;
    w_oreq      = 1'b0;
    w_olock     = 1'b0;
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_cnt_inc   = r_cnt + CW'(1);
    w_cap_hit   = (LOCK_MAX != 0) && (w_cnt_inc >= LMAX);
    case (r_state)
      ARB: begin
        if (i_req0 && i_req1) begin
          w_gnt0 = r_last;
          w_gnt1 = ~r_last;
        end else begin
          w_gnt0 = i_req0;
          w_gnt1 = i_req1;
        end
        if (w_gnt0 || w_gnt1) begin
          w_last_nxt = w_gnt1;
          w_glock    = w_gnt1 ? i_lock1 : i_lock0;
          // A limit of one beat means a lock can never extend ownership.
          if (w_glock && (LOCK_MAX != 1)) begin
            w_state_nxt = w_gnt1 ? HOLD1 : HOLD0;
            w_cnt_nxt   = CW'(1);
          end
        end
      end
      HOLD0, HOLD1: begin
        w_oreq  = (r_state == HOLD1) ? i_req1 : i_req0;
        w_olock = (r_state == HOLD1) ? i_lock1 : i_lock0;
        w_gnt0  = (r_state == HOLD0) && i_req0;
        w_gnt1  = (r_state == HOLD1) && i_req1;
        if (w_oreq) begin
          if (!w_olock || w_cap_hit) begin
            w_state_nxt = ARB;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
          end
        end else if (!w_olock) begin
          w_state_nxt = ARB;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ARB;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // With no grant the address/data mux rests on port 0 and no byte is written.
  assign w_addr_sel  = w_gnt1 ? i_addr1 : i_addr0;
  assign o_mem_addr  = {w_addr_sel[AW-1:3], 3'b000};
  assign o_mem_wdata = w_gnt1 ? i_wdata1 : i_wdata0;
  assign o_mem_we    = (w_gnt0 && i_we0) ? i_be0 :
                       (w_gnt1 && i_we1) ? i_be1 : 8'h00;
  assign o_gnt0      = w_gnt0;
  assign o_gnt1      = w_gnt1;
  assign w_unused    = ^{i_addr0[2:0], i_addr1[2:0]};

  // Read return stage: p0 grant -> p1 data from RAM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid0_p1 <= 1'b0;
      r_rvalid1_p1 <= 1'b0;
    end else begin
      r_rvalid0_p1 <= w_gnt0 && !i_we0;
      r_rvalid1_p1 <= w_gnt1 && !i_we1;
    end
  end

  assign o_rvalid0 = r_rvalid0_p1;
  assign o_rvalid1 = r_rvalid1_p1;
  assign o_rdata   = i_mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, reset-in-lock sequence,
// and randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int LOCK_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, we, lock;
  logic [31:0] addr [2];
  logic [7:0]  be [2];
  logic [63:0] wdata [2];
  logic        o_gnt0, o_gnt1, o_rvalid0, o_rvalid1;
  logic [63:0] o_rdata, o_mem_wdata, mem_rdata;
  logic [7:0]  o_mem_we;
  logic [31:0] o_mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req0(req[0]), .i_req1(req[1]), .i_we0(we[0]), .i_we1(we[1]),
    .i_lock0(lock[0]), .i_lock1(lock[1]),
    .i_addr0(addr[0]), .i_addr1(addr[1]), .i_be0(be[0]), .i_be1(be[1]),
    .i_wdata0(wdata[0]), .i_wdata1(wdata[1]),
    .o_gnt0(o_gnt0), .o_gnt1(o_gnt1), .o_rvalid0(o_rvalid0), .o_rvalid1(o_rvalid1),
    .o_rdata(o_rdata), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata)
  );

  function automatic logic [63:0] pat(input int i);
    return {32'hC0DE0000 + 32'(i), 32'h5A5A0000 ^ 32'(i)};
  endfunction

  // Behavioural RAM: 128 words, byte writes, registered read
  logic        ram_clear;
  logic [63:0] ram [0:127];
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 128; i++) ram[i] <= pat(i);
    end else begin
      for (int b = 0; b < 8; b++)
        if (o_mem_we[b]) ram[o_mem_addr[9:3]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
    end
    mem_rdata <= ram[o_mem_addr[9:3]];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // Reference model: who owns the port, how many beats it has used, who won last.
  int          m_owner, m_beats, m_last;
  logic        m_rv [2];
  logic [63:0] m_rdata;
  logic [63:0] model_mem [0:127];
  logic [1:0]  g_prev;

  task automatic model_reset();
    m_owner = -1; m_beats = 0; m_last = 1;
    m_rv[0] = 1'b0; m_rv[1] = 1'b0; g_prev = 2'b00;
  endtask

  // Called at the negedge: checks all outputs, then advances the model over the posedge.
  task automatic cyc(input string tag);
    logic [1:0]  eg;
    logic [7:0]  ewe;
    logic [31:0] eaddr;
    logic [63:0] ewd;
    int g;
    eg = 2'b00;
    if (m_owner >= 0)           eg[m_owner] = req[m_owner];
    else if (req == 2'b11)      eg[1 - m_last] = 1'b1;
    else                        eg = req;
    g     = eg[1] ? 1 : 0;
    eaddr = {addr[g][31:3], 3'b000};
    ewd   = wdata[g];
    ewe   = (eg[g] && we[g]) ? be[g] : 8'h00;
    chk({tag, ".gnt0"}, 64'(o_gnt0), 64'(eg[0]));
    chk({tag, ".gnt1"}, 64'(o_gnt1), 64'(eg[1]));
    chk({tag, ".rvalid0"}, 64'(o_rvalid0), 64'(m_rv[0]));
    chk({tag, ".rvalid1"}, 64'(o_rvalid1), 64'(m_rv[1]));
    chk({tag, ".mem_we"}, 64'(o_mem_we), 64'(ewe));
    chk({tag, ".mem_addr"}, 64'(o_mem_addr), 64'(eaddr));
    chk({tag, ".mem_wdata"}, o_mem_wdata, ewd);
    if (m_rv[0] || m_rv[1]) chk({tag, ".rdata"}, o_rdata, m_rdata);
    @(posedge clk);
    m_rv[0] = eg[0] && !we[0];
    m_rv[1] = eg[1] && !we[1];
    if (m_rv[0] || m_rv[1]) m_rdata = model_mem[eaddr[9:3]];
    for (int b = 0; b < 8; b++)
      if (ewe[b]) model_mem[eaddr[9:3]][8*b +: 8] = ewd[8*b +: 8];
    if (eg != 2'b00) begin
      m_beats = (m_owner < 0) ? 1 : m_beats + 1;
      m_last  = g;
      if (lock[g] && !(LOCK_MAX != 0 && m_beats >= LOCK_MAX)) m_owner = g;
      else m_owner = -1;
    end else if (m_owner >= 0 && !req[m_owner] && !lock[m_owner]) begin
      m_owner = -1;
    end
    g_prev = eg;
    #1;
  endtask

  typedef struct {
    bit r0, r1, w1, l0, l1;
    logic [31:0] a0, a1;
    bit g0, g1, v0, v1;
    logic [7:0] ew;
    logic [31:0] ea;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(bit r0, bit r1, bit w1, bit l0, bit l1,
                              logic [31:0] a0, logic [31:0] a1,
                              bit g0, bit g1, bit v0, bit v1,
                              logic [7:0] ew, logic [31:0] ea);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.w1 = w1; v.l0 = l0; v.l1 = l1; v.a0 = a0; v.a1 = a1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.ew = ew; v.ea = ea;
    return v;
  endfunction

  logic [63:0] exp_w;

  initial begin
    // r0 r1 w1 l0 l1  a0 a1  g0 g1 v0 v1  we  addr
    tv.push_back(mk(1,0,0,0,0, 32'h10,32'h30, 1,0,0,0, 8'h00,32'h10));
    tv.push_back(mk(0,0,0,0,0, 32'h10,32'h30, 0,0,1,0, 8'h00,32'h10));
    tv.push_back(mk(0,1,0,0,0, 32'h20,32'h30, 0,1,0,0, 8'h00,32'h30));
    tv.push_back(mk(1,1,0,0,0, 32'h20,32'h30, 1,0,0,1, 8'h00,32'h20));
    tv.push_back(mk(1,1,0,0,0, 32'h20,32'h30, 0,1,1,0, 8'h00,32'h30));
    tv.push_back(mk(1,1,0,0,0, 32'h20,32'h30, 1,0,0,1, 8'h00,32'h20));
    tv.push_back(mk(1,1,0,0,0, 32'h20,32'h30, 0,1,1,0, 8'h00,32'h30));
    tv.push_back(mk(0,1,1,0,0, 32'h20,32'h2B, 0,1,0,1, 8'h0F,32'h28));
    tv.push_back(mk(1,0,0,0,0, 32'h28,32'h30, 1,0,0,0, 8'h00,32'h28));
    tv.push_back(mk(0,0,0,0,0, 32'h28,32'h30, 0,0,1,0, 8'h00,32'h28));
    tv.push_back(mk(1,1,0,0,1, 32'h20,32'h30, 0,1,0,0, 8'h00,32'h30));
    tv.push_back(mk(1,1,0,0,1, 32'h20,32'h30, 0,1,0,1, 8'h00,32'h30));
    tv.push_back(mk(1,1,0,0,0, 32'h20,32'h30, 0,1,0,1, 8'h00,32'h30));
    tv.push_back(mk(1,0,0,0,0, 32'h20,32'h30, 1,0,0,1, 8'h00,32'h20));
    tv.push_back(mk(0,1,0,0,0, 32'h20,32'h30, 0,1,1,0, 8'h00,32'h30));
    tv.push_back(mk(1,1,0,1,0, 32'h20,32'h30, 1,0,0,1, 8'h00,32'h20));
    tv.push_back(mk(1,1,0,1,0, 32'h20,32'h30, 1,0,1,0, 8'h00,32'h20));
    tv.push_back(mk(1,1,0,1,0, 32'h20,32'h30, 1,0,1,0, 8'h00,32'h20));
    tv.push_back(mk(1,1,0,1,0, 32'h20,32'h30, 1,0,1,0, 8'h00,32'h20));
    tv.push_back(mk(1,1,0,1,0, 32'h20,32'h30, 0,1,1,0, 8'h00,32'h30));
    tv.push_back(mk(0,0,0,0,0, 32'h20,32'h30, 0,0,0,1, 8'h00,32'h20));

    for (int i = 0; i < 128; i++) model_mem[i] = pat(i);
    model_reset();
    rst_n = 1'b0; ram_clear = 1'b1;
    req = '0; we = '0; lock = '0;
    addr[0] = '0; addr[1] = '0; be[0] = 8'hFF; be[1] = 8'hFF;
    wdata[0] = 64'h0; wdata[1] = 64'h1122334455667788;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.rvalid0", 64'(o_rvalid0), 64'd0);
    chk("reset.rvalid1", 64'(o_rvalid1), 64'd0);
    ram_clear = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tv[i]) begin
      req  = {tv[i].r1, tv[i].r0};
      we   = {tv[i].w1, 1'b0};
      lock = {tv[i].l1, tv[i].l0};
      addr[0] = tv[i].a0; addr[1] = tv[i].a1;
      be[1] = tv[i].w1 ? 8'h0F : 8'hFF;
      @(negedge clk);
      chk($sformatf("vec%0d.gnt0", i), 64'(o_gnt0), 64'(tv[i].g0));
      chk($sformatf("vec%0d.gnt1", i), 64'(o_gnt1), 64'(tv[i].g1));
      chk($sformatf("vec%0d.rvalid0", i), 64'(o_rvalid0), 64'(tv[i].v0));
      chk($sformatf("vec%0d.rvalid1", i), 64'(o_rvalid1), 64'(tv[i].v1));
      chk($sformatf("vec%0d.mem_we", i), 64'(o_mem_we), 64'(tv[i].ew));
      chk($sformatf("vec%0d.mem_addr", i), 64'(o_mem_addr), 64'(tv[i].ea));
      if (i == 1) chk("vec.rdata_0x10", o_rdata, pat(2));
      if (i == 9) begin
        exp_w = pat(5);
        chk("vec.rdata_after_be_write", o_rdata, {exp_w[63:32], 32'h55667788});
      end
      cyc($sformatf("vec%0d", i));
    end

    // Reset while port 1 holds the lock with a read just granted
    req = 2'b10; we = 2'b00; lock = 2'b10; addr[0] = 32'h20; addr[1] = 32'h40;
    be[1] = 8'hFF;
    @(negedge clk); cyc("hold_a");
    req = 2'b11;
    @(negedge clk); cyc("hold_b");
    rst_n = 1'b0;
    #1;
    chk("rst_in_hold.rvalid1", 64'(o_rvalid1), 64'd0);
    chk("rst_in_hold.rvalid0", 64'(o_rvalid0), 64'd0);
    model_reset();
    req = 2'b00; lock = 2'b00;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    req = 2'b11;
    @(negedge clk);
    chk("post_rst_tie.gnt0", 64'(o_gnt0), 64'd1);
    chk("post_rst_tie.gnt1", 64'(o_gnt1), 64'd0);
    cyc("post_rst_tie");
    req = 2'b00;
    @(negedge clk); cyc("post_rst_idle");

    // Randomized traffic; each request stays stable until granted or withdrawn
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (g_prev[p]) req[p] = 1'b0;
        if (req[p] && ($urandom_range(15) == 0)) req[p] = 1'b0;
        else if (!req[p] && ($urandom_range(1) == 1)) begin
          req[p]   = 1'b1;
          we[p]    = 1'($urandom_range(1));
          addr[p]  = 32'($urandom_range(1023));
          be[p]    = 8'($urandom);
          wdata[p] = {$urandom, $urandom};
          lock[p]  = ($urandom_range(2) == 0);
        end else if (!req[p]) begin
          lock[p]  = ($urandom_range(3) == 0);
        end
      end
      @(negedge clk);
      cyc("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
